pdm_demod_decim: RTL

PDM_DEMOD_DECIM -- requirements
Module: pdm_demod_decim

---
 rtl/pdm_demod_decim.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pdm_demod_decim.sv
// ----------------------------------------------------------------------------
// pdm_demod_decim
//
// Turns a 1-bit PDM stream into PCM samples by counting the ones in each
// window of 2^WIN_LOG2 samples. Each count is presented with a valid/ready
// handshake. A sticky overrun flag records that an unconsumed sample was
// overwritten.
//
// Parameters
//   WIN_LOG2   log2 of the window length, and the width of pcm_out
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   pdm_in     1-bit PDM stream, one sample per clk
//   enable     1 = count samples; 0 = window counters held cleared
//   pcm_out    ones count of the last window, saturated to 2^WIN_LOG2-1
//   pcm_valid  pcm_out holds a sample that has not been consumed yet
//   pcm_ready  consumer takes pcm_out on an edge where pcm_valid=1
//   overrun    sticky; set when an unconsumed sample is overwritten
//
// Build option
//   PDM_DEMOD_SYNC_EN  when defined, pdm_in first passes through a two-flop
//                      synchronizer (reset to 0). This adds two cycles of
//                      input latency. When undefined, pdm_in is counted
//                      directly.
// ----------------------------------------------------------------------------
module pdm_demod_decim #(
    parameter int WIN_LOG2 = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pdm_in,
    input  logic                enable,
    output logic [WIN_LOG2-1:0] pcm_out,
    output logic                pcm_valid,
    input  logic                pcm_ready,
    output logic                overrun
);

    localparam logic [WIN_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [WIN_LOG2-1:0] PHASE_ONE  = {{(WIN_LOG2-1){1'b0}}, 1'b1};

    logic                sampleBit;
    logic [WIN_LOG2-1:0] phase_q, phase_d;
    logic [WIN_LOG2:0]   ones_q, ones_d;
    logic [WIN_LOG2-1:0] pcmOut_q, pcmOut_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic [WIN_LOG2:0]   finalCount;
    logic                windowClose;

`ifdef PDM_DEMOD_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer for a PDM source that is not on clk's domain.
    // It runs regardless of enable so that its contents are never stale.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pdm_in;
            sync2_q <= sync1_q;
        end
    end

    assign sampleBit = sync2_q;
`else
    assign sampleBit = pdm_in;
`endif

    // The ones counter is one bit wider than the phase counter. This lets an
    // all-ones window reach 2^WIN_LOG2 before that value is saturated for
    // output.
    assign finalCount  = ones_q + {{WIN_LOG2{1'b0}}, sampleBit};
    assign windowClose = enable && (phase_q == PHASE_LAST);

    // Next-state logic for the window counters and the output handshake.
    // Output register behaviour:
    //   - A window close always loads a new sample, even when the consumer
    //     accepts the old one on the same edge.
    //   - The overwrite counts as an overrun only when the old sample was
    //     still pending and was not being accepted.
    always_comb begin
        phase_d   = phase_q;
        ones_d    = ones_q;
        pcmOut_d  = pcmOut_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (!enable || windowClose) begin
            phase_d = '0;
            ones_d  = '0;
        end else begin
            phase_d = phase_q + PHASE_ONE;
            ones_d  = finalCount;
        end

        if (windowClose) begin
            pcmOut_d = finalCount[WIN_LOG2] ? '1 : finalCount[WIN_LOG2-1:0];
            valid_d  = 1'b1;
            if (valid_q && !pcm_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && pcm_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any partial window and pending sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= '0;
            ones_q    <= '0;
            pcmOut_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            ones_q    <= ones_d;
            pcmOut_q  <= pcmOut_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pcm_out   = pcmOut_q;
    assign pcm_valid = valid_q;
    assign overrun   = overrun_q;

endmodule
